// File: rtl/clint_axi_lite.sv
// Core-local interruptor (mtime, mtimecmp, msip) behind an AXI4-Lite responder.
// Read and write channels are independent. Define CLINT_MSIP_EN to build the msip register.
module clint_axi_lite #(
    parameter logic [31:0] BASE     = 32'h0200_0000,
    parameter int          ADDR_W   = 32,
    parameter int          TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [63:0]       WDATA,
    input  logic [7:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [63:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              clint_mtip,
    output logic              clint_msip
);

    // TICK_DIV must be at least 1; a value of 1 ticks mtime every cycle.
    localparam int                PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] OFF_CMP    = ADDR_W'(32'h0000_4000);
    localparam logic [ADDR_W-1:0] OFF_TIME   = ADDR_W'(32'h0000_BFF8);
`ifdef CLINT_MSIP_EN
    localparam logic [ADDR_W-1:0] OFF_MSIP   = ADDR_W'(32'h0000_0000);
`endif

    typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_CMP, SEL_TIME} sel_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic sel_t decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = (addr - BASE_A) & ~ADDR_W'(7);
        if (off == OFF_CMP)  return SEL_CMP;
        if (off == OFF_TIME) return SEL_TIME;
`ifdef CLINT_MSIP_EN
        if (off == OFF_MSIP) return SEL_MSIP;
`endif
        return SEL_NONE;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_val,
                                          input logic [63:0] data,
                                          input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

    w_state_t        w_state, w_next;
    r_state_t        r_state, r_next;
    sel_t            wr_sel, rd_sel;
    logic            wr_en, rd_en, w_hs_ok, tick;
    logic [63:0]     mtime, mtimecmp, rd_val;
    logic [PW-1:0]   presc;

    assign wr_sel  = decode(AWADDR);
    assign rd_sel  = decode(ARADDR);
    assign w_hs_ok = AWVALID & WVALID & ~rst;
    assign tick    = (presc == PRESC_LAST);

    // Write channel: AW and W are accepted together, then B is held until taken.
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        wr_en   = 1'b0;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = w_hs_ok;
                WREADY  = w_hs_ok;
                wr_en   = w_hs_ok;
                if (w_hs_ok) w_next = W_RESP;
            end
            W_RESP: begin
                BVALID = ~rst;
                if (BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)        BRESP <= 2'b00;
        else if (wr_en) BRESP <= (wr_sel == SEL_NONE) ? 2'b10 : 2'b00;
    end

    // Read channel: data is captured at the AR handshake and held until taken.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        rd_en   = 1'b0;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = ~rst;
                rd_en   = ARVALID & ~rst;
                if (rd_en) r_next = R_DATA;
            end
            R_DATA: begin
                RVALID = ~rst;
                if (RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

`ifdef CLINT_MSIP_EN
    logic msip;
`endif

    always_comb begin
        rd_val = '0;
        case (rd_sel)
            SEL_CMP:  rd_val = mtimecmp;
            SEL_TIME: rd_val = mtime;
`ifdef CLINT_MSIP_EN
            SEL_MSIP: rd_val = {63'd0, msip};
`endif
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RDATA <= '0;
            RRESP <= 2'b00;
        end else if (rd_en) begin
            RDATA <= rd_val;
            RRESP <= (rd_sel == SEL_NONE) ? 2'b10 : 2'b00;
        end
    end

    // Timer: a write to mtime wins over a same-cycle tick, which is then lost.
    always_ff @(posedge clk) begin
        if (rst) presc <= '0;
        else     presc <= tick ? '0 : presc + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)                              mtime <= '0;
        else if (wr_en && wr_sel == SEL_TIME) mtime <= merge(mtime, WDATA, WSTRB);
        else if (tick)                        mtime <= mtime + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)                             mtimecmp <= '1;
        else if (wr_en && wr_sel == SEL_CMP) mtimecmp <= merge(mtimecmp, WDATA, WSTRB);
    end

    always_ff @(posedge clk) begin
        if (rst) clint_mtip <= 1'b0;
        else     clint_mtip <= (mtime >= mtimecmp);
    end

`ifdef CLINT_MSIP_EN
    always_ff @(posedge clk) begin
        if (rst)                                       msip <= 1'b0;
        else if (wr_en && wr_sel == SEL_MSIP && WSTRB[0]) msip <= WDATA[0];
    end

    always_ff @(posedge clk) begin
        if (rst) clint_msip <= 1'b0;
        else     clint_msip <= msip;
    end
`else
    assign clint_msip = 1'b0;
`endif

endmodule

// File: tb/tb_clint_axi_lite.sv
// Self-checking bench for clint_axi_lite: directed table, corner sequences and randomized traffic
// against a cycle-indexed reference model of the register file.
module tb_clint_axi_lite;

    localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef CLINT_MSIP_EN
    localparam bit MSIP_EN = 1'b1;
`else
    localparam bit MSIP_EN = 1'b0;
`endif

    logic        clk, rst;
    logic [31:0] AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        clint_mtip, clint_msip;

    clint_axi_lite #(.BASE(BASE), .ADDR_W(32), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .clint_mtip(clint_mtip), .clint_msip(clint_msip)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic mtip_hist [0:16383];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 16384) mtip_hist[cyc] <= clint_mtip;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: mtime is base + elapsed cycles since the cycle it was last set.
    logic [63:0] m_base, m_cmp;
    int          m_base_cyc, m_cmp_cyc, m_msip_cyc;
    logic        m_msip;

    function automatic logic [63:0] m_time(input int c);
        return m_base + 64'(c - m_base_cyc);
    endfunction

    function automatic int m_sel(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) & 32'hFFFF_FFF8;
        if (off == 32'h4000) return 2;
        if (off == 32'hBFF8) return 3;
        if (MSIP_EN && off == 32'h0) return 1;
        return 0;
    endfunction

    function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_read(input logic [31:0] a, input int c);
        case (m_sel(a))
            1:       return {63'd0, m_msip};
            2:       return m_cmp;
            3:       return m_time(c);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return (m_sel(a) == 0) ? 2'b10 : 2'b00;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input int hs);
        case (m_sel(a))
            1: begin if (s[0]) m_msip = d[0]; m_msip_cyc = hs + 1; end
            2: begin m_cmp = bmerge(m_cmp, d, s); m_cmp_cyc = hs + 1; end
            3: begin m_base = bmerge(m_time(hs), d, s); m_base_cyc = hs + 1; end
            default: ;
        endcase
    endtask

    task automatic m_reset(input int c);
        m_base = '0;  m_base_cyc = c;
        m_cmp  = '1;  m_cmp_cyc  = c;
        m_msip = 1'b0; m_msip_cyc = c;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit hist_at(input int c);
        if (c < 0 || c > 16383) return 1'bx;
        return mtip_hist[c];
    endfunction

    // All tasks start and end at #1 after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] resp, output int hs);
        int bc;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        hs = -1; bc = -1; resp = 2'bxx;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (AWREADY && WREADY) begin hs = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("aw_w_handshake_seen", 64'(hs >= 0), 64'd1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (BVALID) begin bc = cyc; resp = BRESP; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("bvalid_latency", 64'(bc), 64'(hs + 1));
    endtask

    task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                           output int hs);
        int rc;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        hs = -1; rc = -1; d = 'x; resp = 2'bxx;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ARREADY) begin hs = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ARVALID = 1'b0;
        chk("ar_handshake_seen", 64'(hs >= 0), 64'd1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (RVALID) begin rc = cyc; d = RDATA; resp = RRESP; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("rvalid_latency", 64'(rc), 64'(hs + 1));
    endtask

    task automatic chk_irq(input string tag);
        int c;
        c = cyc;
        if (c - 1 >= m_base_cyc && c - 1 >= m_cmp_cyc)
            chk({tag, "_mtip"}, 64'(clint_mtip), 64'(m_time(c - 1) >= m_cmp));
        if (c - 1 >= m_msip_cyc)
            chk({tag, "_msip"}, 64'(clint_msip), 64'(MSIP_EN & m_msip));
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] off;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [1:0]  resp;
        logic [63:0] rdata;
    } vec_t;

    vec_t        tbl [12];
    logic [63:0] rd, rd2, exp_d, wd;
    logic [1:0]  rr, wr;
    logic [31:0] wa, ra;
    logic [7:0]  ws;
    int          hs, whs, rhs, c0, rise;

    function automatic logic [31:0] rand_addr();
        logic [31:0] off;
        case ($urandom_range(0, 5))
            0:       off = 32'h0;
            1, 2:    off = 32'h4000;
            3:       off = 32'hBFF8;
            4:       off = 32'h100;
            default: off = $urandom_range(0, 16'hFFFF) & 32'hFFF8;
        endcase
        return BASE + off + 32'($urandom_range(0, 7));
    endfunction

    initial begin
        tbl[0]  = '{0, 32'h4000, 64'h0, 8'h00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[1]  = '{1, 32'h4000, 64'h0000_0000_1234_5678, 8'h0F, 2'b00, 64'h0};
        tbl[2]  = '{0, 32'h4000, 64'h0, 8'h00, 2'b00, 64'hFFFF_FFFF_1234_5678};
        tbl[3]  = '{0, 32'h0100, 64'h0, 8'h00, 2'b10, 64'h0};
        tbl[4]  = '{1, 32'h0100, 64'h0, 8'hFF, 2'b10, 64'h0};
        tbl[5]  = '{0, 32'h4000, 64'h0, 8'h00, 2'b00, 64'hFFFF_FFFF_1234_5678};
        tbl[6]  = '{1, 32'h4000, 64'hAABB_0000_0000_0000, 8'hC0, 2'b00, 64'h0};
        tbl[7]  = '{1, 32'h4004, 64'h0000_0000_0000_0099, 8'h01, 2'b00, 64'h0};
        tbl[8]  = '{0, 32'h4007, 64'h0, 8'h00, 2'b00, 64'hAABB_FFFF_1234_5699};
        tbl[9]  = '{1, 32'h0000, 64'h1, 8'h01, MSIP_EN ? 2'b00 : 2'b10, 64'h0};
        tbl[10] = '{0, 32'h0000, 64'h0, 8'h00, MSIP_EN ? 2'b00 : 2'b10, MSIP_EN ? 64'h1 : 64'h0};
        tbl[11] = '{0, 32'h8000, 64'h0, 8'h00, 2'b10, 64'h0};

        // Reset with all valids high: nothing may be accepted.
        rst = 1'b1; AWADDR = BASE + 32'h4000; ARADDR = BASE + 32'h4000;
        WDATA = '0; WSTRB = '0; AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("reset_ctrl_outputs",
            64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, clint_mtip, clint_msip}), 64'd0);
        chk("reset_rdata", RDATA, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        m_reset(cyc);

        // A pending R response is dropped by a mid-transaction reset.
        ARVALID = 1'b1; RREADY = 1'b0;
        @(negedge clk); chk("arready_after_reset", 64'(ARREADY), 64'd1);
        @(posedge clk); #1; ARVALID = 1'b0;
        @(negedge clk); chk("rvalid_stalled", 64'(RVALID), 64'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rvalid_dropped_in_reset", 64'(RVALID), 64'd0);
        chk("arready_in_reset", 64'(ARREADY), 64'd0);
        @(posedge clk); #1; rst = 1'b0; RREADY = 1'b1; m_reset(cyc);
        @(negedge clk); chk("rvalid_after_reset", 64'(RVALID), 64'd0);
        @(posedge clk); #1;

        do_read(BASE + 32'hBFF8, rd, rr, hs);
        chk("reset_mtime_resp", rr, 2'b00);
        chk("reset_mtime", rd, m_time(hs));
        chk("reset_mtime_small", 64'(rd < 64'd16), 64'd1);
        do_read(BASE + 32'h4000, rd, rr, hs);
        chk("reset_mtimecmp_resp", rr, 2'b00);
        chk("reset_mtimecmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("reset_mtip", 64'(clint_mtip), 64'd0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                do_write(BASE + tbl[i].off, tbl[i].wdata, tbl[i].strb, wr, hs);
                chk($sformatf("tbl%0d_bresp", i), wr, tbl[i].resp);
                m_write(BASE + tbl[i].off, tbl[i].wdata, tbl[i].strb, hs);
            end else begin
                do_read(BASE + tbl[i].off, rd, rr, hs);
                chk($sformatf("tbl%0d_rresp", i), rr, tbl[i].resp);
                chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
            end
        end
        chk("msip_output", 64'(clint_msip), 64'(MSIP_EN));
        do_read(BASE + 32'hBFF8, rd, rr, hs);
        chk("mtime_after_unmapped_write", rd, m_time(hs));

        // Timer compare: mtip rises the cycle after mtime reaches mtimecmp.
        do_write(BASE + 32'hBFF8, 64'd0, 8'hFF, wr, hs);
        chk("timer_mtime_bresp", wr, 2'b00);
        m_write(BASE + 32'hBFF8, 64'd0, 8'hFF, hs);
        do_write(BASE + 32'h4000, 64'h20, 8'hFF, wr, whs);
        chk("timer_cmp_bresp", wr, 2'b00);
        m_write(BASE + 32'h4000, 64'h20, 8'hFF, whs);
        c0 = m_base_cyc + 32;
        for (int n = 0; n < 200 && cyc < c0 + 3; n++) begin @(posedge clk); #1; end
        rise = -1;
        for (int c = whs + 1; c <= c0 + 2; c++) if (rise < 0 && hist_at(c) === 1'b1) rise = c;
        chk("mtip_rise_cycle", 64'(rise), 64'(c0 + 1));
        do_write(BASE + 32'h4000, 64'h1000, 8'hFF, wr, whs);
        m_write(BASE + 32'h4000, 64'h1000, 8'hFF, whs);
        @(negedge clk); @(posedge clk); #1;
        chk("mtip_held_n_plus_1", 64'(hist_at(whs + 1)), 64'd1);
        chk("mtip_drop_n_plus_2", 64'(hist_at(whs + 2)), 64'd0);

        // Read backpressure.
        ARADDR = BASE + 32'h4000; ARVALID = 1'b1; RREADY = 1'b0; hs = -1;
        for (int n = 0; n < 20 && hs < 0; n++) begin
            @(negedge clk); if (ARREADY) hs = cyc;
            @(posedge clk); #1;
        end
        ARVALID = 1'b0;
        exp_d = m_read(BASE + 32'h4000, hs);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rvalid", 64'(RVALID), 64'd1);
            chk("bp_rdata", RDATA, exp_d);
            chk("bp_arready", 64'(ARREADY), 64'd0);
            @(posedge clk); #1;
        end
        RREADY = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); chk("bp_r_released", 64'({RVALID, ARREADY}), 64'b01);
        @(posedge clk); #1;

        // Write backpressure with a second write already offered.
        AWADDR = BASE + 32'h4000; WDATA = 64'h1000; WSTRB = 8'hFF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0; hs = -1;
        for (int n = 0; n < 20 && hs < 0; n++) begin
            @(negedge clk); if (AWREADY && WREADY) hs = cyc;
            @(posedge clk); #1;
        end
        m_write(BASE + 32'h4000, 64'h1000, 8'hFF, hs);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_bvalid", 64'({BVALID, BRESP}), 64'b100);
            chk("bp_aw_w_ready", 64'({AWREADY, WREADY}), 64'd0);
            @(posedge clk); #1;
        end
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); chk("bp_b_released", 64'(BVALID), 64'd0);
        @(posedge clk); #1;

        // Same-cycle read and write of mtime; then wrap through zero.
        fork
            do_write(BASE + 32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, wr, whs);
            do_read(BASE + 32'hBFF8, rd, rr, rhs);
        join
        chk("collide_same_cycle", 64'(rhs), 64'(whs));
        chk("collide_read_old", rd, m_time(rhs));
        m_write(BASE + 32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, whs);
        fork
            do_write(BASE + 32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, wr, whs);
            begin @(posedge clk); #1; do_read(BASE + 32'hBFF8, rd, rr, rhs); end
        join
        m_write(BASE + 32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, whs);
        chk("wrap_first", rd, 64'hFFFF_FFFF_FFFF_FFFE);
        do_read(BASE + 32'hBFF8, rd2, rr, hs);
        chk("wrap_second", rd2, 64'd0);
        chk("wrap_model", rd2, m_time(hs));

        // Randomized traffic against the model.
        for (int t = 0; t < 150; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            wa = rand_addr(); ra = rand_addr();
            wd = {$urandom, $urandom}; ws = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                do_write(wa, wd, ws, wr, whs);
                chk("rnd_bresp", wr, m_resp(wa));
                m_write(wa, wd, ws, whs);
            end else if (kind == 1) begin
                do_read(ra, rd, rr, rhs);
                chk("rnd_rresp", rr, m_resp(ra));
                chk("rnd_rdata", rd, m_read(ra, rhs));
            end else begin
                fork
                    do_write(wa, wd, ws, wr, whs);
                    do_read(ra, rd, rr, rhs);
                join
                chk("rnd2_bresp", wr, m_resp(wa));
                chk("rnd2_rresp", rr, m_resp(ra));
                if (whs < rhs) begin
                    m_write(wa, wd, ws, whs);
                    exp_d = m_read(ra, rhs);
                end else begin
                    exp_d = m_read(ra, rhs);
                    m_write(wa, wd, ws, whs);
                end
                chk("rnd2_rdata", rd, exp_d);
            end
            chk_irq("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
